// File: rtl/ysyx_22040237_lsu.sv
// Multi-cycle load/store unit: request/grant/response data port, lane alignment, load extension.
// Optional misaligned-access trap: define YSYX_22040237_LSU_MISALIGN_CHK_EN.
//
// state | meaning
// IDLE  | ready for an issue
// REQ   | memory request held until grant
// RESP  | load waiting for read data
// DONE  | one-cycle writeback beat
module ysyx_22040237_lsu #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ls_valid_i,
    input  logic [6:0]        ls_info_bus_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              rd_wr_en_i,
    input  logic [4:0]        rd_idx_i,
    output logic              ls_ready_o,
    output logic              lsu_busy_o,
    output logic              wb_valid_o,
    output logic              wb_rd_wr_en_o,
    output logic [4:0]        wb_rd_idx_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              misalign_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [7:0]        mem_wmask_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    // size code: 0 = byte, 1 = half, 2 = word, 3 = doubleword
    function automatic logic [1:0] size_of(input logic [6:0] info);
        if (info[6])      size_of = 2'd3;
        else if (info[5]) size_of = 2'd2;
        else if (info[4]) size_of = 2'd1;
        else if (info[3]) size_of = 2'd0;
        else              size_of = 2'd3;
    endfunction

    state_t            state, state_nxt;
    logic              store_q, usign_q, wen_q, mis_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, data_q;
    logic [4:0]        idx_q;

    logic [1:0]        size_in;
    logic              access_in, mis_in;
    logic [2:0]        off;
    logic [7:0]        size_mask;
    logic [DATA_W-1:0] ld_shift, ld_ext;

    assign size_in   = size_of(ls_info_bus_i);
    assign access_in = ls_info_bus_i[0] | ls_info_bus_i[1];

`ifdef YSYX_22040237_LSU_MISALIGN_CHK_EN
    always_comb begin
        mis_in = 1'b0;
        case (size_in)
            2'd1:    mis_in = addr_i[0];
            2'd2:    mis_in = |addr_i[1:0];
            2'd3:    mis_in = |addr_i[2:0];
            default: mis_in = 1'b0;
        endcase
        mis_in = mis_in & access_in;
    end
`else
    assign mis_in = 1'b0;
`endif

    assign off = addr_q[2:0];

    always_comb begin
        size_mask = 8'hFF;
        case (size_q)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    assign ld_shift = mem_rdata_i >> {off, 3'b000};

    always_comb begin
        ld_ext = ld_shift;
        case (size_q)
            2'd0:    ld_ext = {{56{~usign_q & ld_shift[7]}},  ld_shift[7:0]};
            2'd1:    ld_ext = {{48{~usign_q & ld_shift[15]}}, ld_shift[15:0]};
            2'd2:    ld_ext = {{32{~usign_q & ld_shift[31]}}, ld_shift[31:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ls_valid_i) state_nxt = (access_in && !mis_in) ? REQ : DONE;
            REQ:  if (mem_gnt_i) state_nxt = store_q ? DONE : RESP;
            RESP: if (mem_rvalid_i) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            store_q <= 1'b0;
            usign_q <= 1'b0;
            wen_q   <= 1'b0;
            mis_q   <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            idx_q   <= '0;
        end else begin
            case (state)
                IDLE: if (ls_valid_i) begin
                    store_q <= ls_info_bus_i[1];
                    usign_q <= ls_info_bus_i[2];
                    size_q  <= size_in;
                    wen_q   <= rd_wr_en_i;
                    idx_q   <= rd_idx_i;
                    addr_q  <= addr_i;
                    wdata_q <= wdata_i;
                    mis_q   <= mis_in;
                    // pass-through and misaligned beats return the address
                    data_q  <= addr_i;
                end
                REQ:  if (mem_gnt_i && store_q) data_q <= '0;
                RESP: if (mem_rvalid_i) data_q <= ld_ext;
                default: ;
            endcase
        end
    end

    assign ls_ready_o    = (state == IDLE);
    assign lsu_busy_o    = ~ls_ready_o;

    assign mem_req_o     = (state == REQ);
    assign mem_we_o      = mem_req_o & store_q;
    assign mem_addr_o    = mem_req_o ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
    assign mem_wdata_o   = mem_req_o ? (wdata_q << {off, 3'b000}) : '0;
    assign mem_wmask_o   = mem_req_o ? (size_mask << off) : 8'h00;

    assign wb_valid_o    = (state == DONE);
    assign wb_rd_wr_en_o = wb_valid_o & wen_q & ~store_q & ~mis_q;
    assign wb_rd_idx_o   = wb_valid_o ? idx_q : 5'd0;
    assign wb_data_o     = wb_valid_o ? data_q : '0;
    assign misalign_o    = wb_valid_o & mis_q;

endmodule

// File: tb/tb_ysyx_22040237_lsu.sv
// Scoreboard bench for ysyx_22040237_lsu: directed issues push expected writeback beats,
// a monitor pops and compares each beat the DUT presents.
module tb_ysyx_22040237_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        ls_valid_i;
    logic [6:0]  ls_info_bus_i;
    logic [63:0] addr_i, wdata_i;
    logic        rd_wr_en_i;
    logic [4:0]  rd_idx_i;
    logic        ls_ready_o, lsu_busy_o, wb_valid_o, wb_rd_wr_en_o, misalign_o;
    logic [4:0]  wb_rd_idx_o;
    logic [63:0] wb_data_o;
    logic        mem_req_o, mem_we_o;
    logic [63:0] mem_addr_o, mem_wdata_o;
    logic [7:0]  mem_wmask_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [63:0] mem_rdata_i;

    ysyx_22040237_lsu dut (
        .clk(clk), .rst(rst), .ls_valid_i(ls_valid_i), .ls_info_bus_i(ls_info_bus_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rd_wr_en_i(rd_wr_en_i), .rd_idx_i(rd_idx_i),
        .ls_ready_o(ls_ready_o), .lsu_busy_o(lsu_busy_o), .wb_valid_o(wb_valid_o),
        .wb_rd_wr_en_o(wb_rd_wr_en_o), .wb_rd_idx_o(wb_rd_idx_o), .wb_data_o(wb_data_o),
        .misalign_o(misalign_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  idx;
        logic        wen;
        logic        mis;
        int          cyc;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    pushed = 0;
    int    pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && wb_valid_o) begin
            beat_t e;
            pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_wb: got wb_valid at cycle %0d expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("wb_data", wb_data_o, e.data);
                chk("wb_rd_idx", 64'(wb_rd_idx_o), 64'(e.idx));
                chk("wb_rd_wr_en", 64'(wb_rd_wr_en_o), 64'(e.wen));
                chk("misalign", 64'(misalign_o), 64'(e.mis));
                chk("wb_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // drive one issue at a negedge; returns at the negedge of cycle T+1
    task automatic issue(input logic [6:0] info, input logic [63:0] a, input logic [63:0] wd,
                         input logic wen, input logic [4:0] idx, input logic expect_wb,
                         input logic [63:0] edata, input logic ewen, input logic emis, input int lat);
        beat_t e;
        ls_valid_i = 1'b1; ls_info_bus_i = info; addr_i = a; wdata_i = wd;
        rd_wr_en_i = wen; rd_idx_i = idx;
        if (expect_wb) begin
            e.data = edata; e.idx = idx; e.wen = ewen; e.mis = emis; e.cyc = cyc + lat;
            exp_q.push_back(e);
            pushed++;
        end
        @(negedge clk);
        ls_valid_i = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ls_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ls_ready_o) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: got ls_ready_o=0 expected 1 within 50 cycles");
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; ls_valid_i = 1'b0; ls_info_bus_i = '0; addr_i = '0; wdata_i = '0;
        rd_wr_en_i = 1'b0; rd_idx_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(ls_ready_o), 64'd1);
        chk("rst_busy", 64'(lsu_busy_o), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("rst_wb_data", wb_data_o, 64'd0);
        chk("rst_mem_req", 64'(mem_req_o), 64'd0);
        chk("rst_wmask", 64'(mem_wmask_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // sb with immediate grant
        mem_gnt_i = 1'b1;
        issue(7'h0A, 64'h8000_0005, 64'h0000_0000_0000_00AB, 1'b1, 5'd7, 1'b1, 64'd0, 1'b0, 1'b0, 2);
        chk("sb_req", 64'(mem_req_o), 64'd1);
        chk("sb_we", 64'(mem_we_o), 64'd1);
        chk("sb_addr", mem_addr_o, 64'h8000_0000);
        chk("sb_wmask", 64'(mem_wmask_o), 64'h20);
        chk("sb_wdata", mem_wdata_o, 64'h0000_AB00_0000_0000);
        chk("sb_busy", 64'(lsu_busy_o), 64'd1);
        wait_ready();

        // lb signed, rvalid at first RESP cycle
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h0000_0000_8000_0000;
        issue(7'h09, 64'h8000_0003, 64'd0, 1'b1, 5'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0, 3);
        chk("lb_we", 64'(mem_we_o), 64'd0);
        chk("lb_wmask", 64'(mem_wmask_o), 64'h08);
        wait_ready();

        mem_rdata_i = 64'h8765_4321_0000_0000;
        issue(7'h25, 64'h8000_0004, 64'd0, 1'b1, 5'd10, 1'b1, 64'h0000_0000_8765_4321, 1'b1, 1'b0, 3);
        wait_ready();
        issue(7'h21, 64'h8000_0004, 64'd0, 1'b1, 5'd11, 1'b1, 64'hFFFF_FFFF_8765_4321, 1'b1, 1'b0, 3);
        wait_ready();

        // no size bit, and multiple size bits (dw wins): full doubleword
        mem_rdata_i = 64'hDEAD_BEEF_CAFE_F00D;
        issue(7'h01, 64'h8000_0008, 64'd0, 1'b1, 5'd12, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1'b0, 3);
        chk("ld_nosize_wmask", 64'(mem_wmask_o), 64'hFF);
        wait_ready();
        issue(7'h59, 64'h8000_0010, 64'd0, 1'b1, 5'd13, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1'b0, 3);
        chk("ld_prio_wmask", 64'(mem_wmask_o), 64'hFF);
        wait_ready();

        // pass-through: neither load nor store
        issue(7'h00, 64'h0000_0000_0000_1234, 64'd0, 1'b1, 5'd3, 1'b1, 64'h1234, 1'b1, 1'b0, 1);
        wait_ready();

        // sd with grant held off for five cycles
        mem_gnt_i = 1'b0;
        issue(7'h42, 64'h8000_0010, 64'h1122_3344_5566_7788, 1'b1, 5'd9, 1'b1, 64'd0, 1'b0, 1'b0, 7);
        for (int i = 0; i < 6; i++) begin
            chk("stall_req", 64'(mem_req_o), 64'd1);
            chk("stall_addr", mem_addr_o, 64'h8000_0010);
            chk("stall_wdata", mem_wdata_o, 64'h1122_3344_5566_7788);
            chk("stall_wmask", 64'(mem_wmask_o), 64'hFF);
            chk("stall_ready", 64'(ls_ready_o), 64'd0);
            if (i == 5) mem_gnt_i = 1'b1;
            @(negedge clk);
        end
        wait_ready();

        // reset while in RESP, then a stale rvalid
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0;
        issue(7'h41, 64'h8000_0020, 64'd0, 1'b1, 5'd14, 1'b0, 64'd0, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("resp_req", 64'(mem_req_o), 64'd0);
        chk("resp_ready", 64'(ls_ready_o), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_req", 64'(mem_req_o), 64'd0);
        mem_rvalid_i = 1'b1;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        chk("stale_ready", 64'(ls_ready_o), 64'd1);
        chk("stale_wb", 64'(wb_valid_o), 64'd0);
        @(negedge clk);

        // lh at odd address
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h0000_0000_00BE_EF00;
`ifdef YSYX_22040237_LSU_MISALIGN_CHK_EN
        issue(7'h11, 64'h8000_0001, 64'd0, 1'b1, 5'd15, 1'b1, 64'h8000_0001, 1'b0, 1'b1, 1);
        chk("mis_req", 64'(mem_req_o), 64'd0);
`else
        issue(7'h11, 64'h8000_0001, 64'd0, 1'b1, 5'd15, 1'b1, 64'hFFFF_FFFF_FFFF_BEEF, 1'b1, 1'b0, 3);
        chk("mis_req", 64'(mem_req_o), 64'd1);
        chk("mis_wmask", 64'(mem_wmask_o), 64'h06);
`endif
        wait_ready();
        mem_rvalid_i = 1'b0;

        repeat (4) @(negedge clk);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        chk("pulse_count", 64'(pulses), 64'(pushed));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
